// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//
// Bit-serial adder sequencer. A single one-bit full adder is reused WIDTH
// times: the operands are shifted out LSB-first, the carry is held in a
// register between bits, and each sum bit enters the MSB of a sum shift
// register. The finished word and carry-out are copied to the outputs, and
// done pulses for one cycle.
//
// Parameters
//   WIDTH  operand/sum width in bits (1..32)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin an addition (sampled only while idle)
//   a, b   WIDTH-bit operands, captured on the accepting start edge
//   cin    carry-in, captured on the accepting start edge
//   busy   high while bits are being processed
//   done   one-cycle pulse when sum/cout have just been updated
//   sum    registered result, (a+b+cin) mod 2^WIDTH
//   cout   registered carry-out, bit WIDTH of a+b+cin

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The bit counter needs at least one bit even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;
  logic             load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. busy and done are pure decodes of the
  // state register, so no input reaches an output combinationally. start is
  // only looked at in IDLE; DONE always returns to IDLE, so a request held
  // high through DONE is taken on the first IDLE edge afterwards.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-bit full adder on the operand LSBs and the held carry. The new sum
  // bit goes into the MSB so that after WIDTH shifts the LSB-first stream
  // lines up as a normal word. Writing the shift as a shift-then-insert
  // keeps it legal for WIDTH=1.
  always_comb begin
    fa_sum                 = a_sh[0] ^ b_sh[0] ^ carry;
    fa_carry               = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    sum_sh_next            = sum_sh >> 1;
    sum_sh_next[WIDTH-1]   = fa_sum;
    last_bit               = (cnt == CW'(WIDTH - 1));
  end

  // Datapath registers. The visible sum/cout only change on the final bit,
  // so they keep the previous result for the whole of RUN, and a reset
  // mid-run discards the partial work without touching them again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (busy) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_sh_next;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= sum_sh_next;
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl at WIDTH=8, 1 and 32. Expected
// {cout,sum} words are computed from the operands and queued when an
// addition is requested, then popped and compared when done pulses.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge as well, half a cycle away from the active edge.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Expected {cout,sum} words, zero-extended, oldest first.
  logic [63:0] sb[$];

  // Reference model: WIDTH-bit a+b+cin including the carry-out bit.
  function automatic logic [63:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic c);
    logic [63:0] mask;
    mask  = (64'd1 << w) - 64'd1;
    return (av & mask) + (bv & mask) + {63'd0, c};
  endfunction

  function automatic logic [63:0] get_res(input int w);
    logic [63:0] r;
    r = '0;
    case (w)
      1:       r[1:0]  = {cout1, sum1};
      8:       r[8:0]  = {cout8, sum8};
      default: r[32:0] = {cout32, sum32};
    endcase
    return r;
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy32;
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [63:0] av,
                       input logic [63:0] bv, input logic c);
    case (w)
      1:       begin start1  = s; a1  = av[0:0];  b1  = bv[0:0];  cin1  = c; end
      8:       begin start8  = s; a8  = av[7:0];  b8  = bv[7:0];  cin8  = c; end
      default: begin start32 = s; a32 = av[31:0]; b32 = bv[31:0]; cin32 = c; end
    endcase
  endtask

  task automatic set_start(input int w, input logic s);
    case (w)
      1:       start1  = s;
      8:       start8  = s;
      default: start32 = s;
    endcase
  endtask

  // Waits (bounded) for the next done pulse; cycles counts falling edges.
  task automatic wait_done(input int w, input int limit, output int cycles,
                           output bit ok);
    ok     = 1'b0;
    cycles = 0;
    while (cycles < limit && !ok) begin
      @(negedge clk);
      cycles++;
      if (get_done(w) === 1'b1) ok = 1'b1;
    end
  endtask

  // Issues one start pulse from IDLE and collects the outcome. Latency is
  // counted from the falling edge right after the accepting edge, so a
  // WIDTH-cycle latency reads back as WIDTH.
  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input logic c, output logic busy_after_start,
                        output int latency, output bit ok,
                        output logic [63:0] got, output logic busy_at_done);
    @(negedge clk);
    drive(w, 1'b1, av, bv, c);
    sb.push_back(model(w, av, bv, c));
    @(negedge clk);
    set_start(w, 1'b0);
    busy_after_start = get_busy(w);
    wait_done(w, w + 8, latency, ok);
    got          = get_res(w);
    busy_at_done = get_busy(w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(8, 1'b1, {32'd0, $urandom}, {32'd0, $urandom}, 1'b1);
    drive(1, 1'b1, 64'd1, 64'd1, 1'b1);
    drive(32, 1'b1, {32'd0, $urandom}, {32'd0, $urandom}, 1'b1);
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy8, done8, cout8, sum8);
    end
    vectors++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_w1: got %b%b%b%b, want 0000", busy1, done1, cout1, sum1);
    end
    vectors++;
    if ({busy32, done32, cout32, sum32} !== 35'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_w32: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy32, done32, cout32, sum32);
    end
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy8, done8, cout8, sum8} !== 11'd0 || busy32 !== 1'b0 || busy1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_reset_idle[%0d]: got busy=%b done=%b sum=%h, want idle zeros",
                 i, busy8, done8, sum8);
      end
    end
  endtask

  task automatic test_basic();
    logic        bs, bd;
    int          lat;
    bit          ok;
    logic [63:0] got, exp;
    run_op(8, 64'h5A, 64'h33, 1'b0, bs, lat, ok, got, bd);
    exp = sb.pop_front();
    vectors++;
    if (bs !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy: got %b, want 1", bs);
    end
    vectors++;
    if (!ok || lat != 8) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d (seen=%0b), want 8", lat, ok);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL basic_sum: got %h, want %h", got, exp);
    end
    vectors++;
    if (bd !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_with_done: got busy=%b, want 0", bd);
    end
    @(negedge clk);
    vectors++;
    if (done8 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_done_width: got done=%b one cycle later, want 0", done8);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({cout8, sum8} !== 9'h08D) begin
      miscompares++;
      $display("[TB] FAIL basic_hold: got %h, want 08d", {cout8, sum8});
    end
  endtask

  task automatic test_carry();
    logic [7:0]  ta[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0]  tb_[3] = '{8'h01, 8'hFF, 8'h00};
    logic        tc[3] = '{1'b0, 1'b1, 1'b1};
    logic        bs, bd;
    int          lat;
    bit          ok;
    logic [63:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      run_op(8, {56'd0, ta[i]}, {56'd0, tb_[i]}, tc[i], bs, lat, ok, got, bd);
      exp = sb.pop_front();
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("[TB] FAIL carry[%0d]: got %h (seen=%0b), want %h", i, got, ok, exp);
      end
    end
  endtask

  // start held high throughout; operands changed after acceptance. Each
  // accepted start costs one IDLE edge + 8 RUN edges + one DONE edge, so
  // the second done follows the first by 10 cycles.
  task automatic test_back_to_back();
    int          cyc, k, extra;
    bit          ok;
    logic [63:0] exp;
    extra = 0;
    @(negedge clk);
    drive(8, 1'b1, 64'h10, 64'h20, 1'b0);
    sb.push_back(model(8, 64'h10, 64'h20, 1'b0));
    @(negedge clk);
    drive(8, 1'b1, 64'hAA, 64'h55, 1'b0);
    wait_done(8, 20, cyc, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || {cout8, sum8} !== exp[8:0]) begin
      miscompares++;
      $display("[TB] FAIL held_first: got %h (seen=%0b), want %h", {cout8, sum8}, ok, exp[8:0]);
    end
    sb.push_back(model(8, 64'hAA, 64'h55, 1'b0));
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (done8 === 1'b1) extra++;
    end while (busy8 !== 1'b1 && k < 6);
    start8 = 1'b0;
    vectors++;
    if (k != 2) begin
      miscompares++;
      $display("[TB] FAIL held_restart: got busy after %0d cycles, want 2", k);
    end
    wait_done(8, 20, cyc, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || k + cyc != 10) begin
      miscompares++;
      $display("[TB] FAIL held_spacing: got %0d cycles (seen=%0b), want 10", k + cyc, ok);
    end
    vectors++;
    if ({cout8, sum8} !== exp[8:0]) begin
      miscompares++;
      $display("[TB] FAIL held_second: got %h, want %h", {cout8, sum8}, exp[8:0]);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("[TB] FAIL held_extra_done: got %0d extra pulses, want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    logic        bs, bd;
    int          lat, dones;
    bit          ok;
    logic [63:0] got, exp;
    run_op(8, 64'h5A, 64'h33, 1'b0, bs, lat, ok, got, bd);
    exp = sb.pop_front();
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("[TB] FAIL midrst_prior: got %h, want %h", got, exp);
    end
    @(negedge clk);
    drive(8, 1'b1, 64'hF0, 64'h0F, 1'b0);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_clear: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy8, done8, cout8, sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || sum8 !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_done: got %0d pulses sum=%h, want 0 pulses sum=00", dones, sum8);
    end
    run_op(8, 64'h01, 64'h02, 1'b1, bs, lat, ok, got, bd);
    exp = sb.pop_front();
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("[TB] FAIL midrst_after: got %h (seen=%0b), want %h", got, ok, exp);
    end
  endtask

  // Continuous start=1 stream of random additions at one width. New
  // operands are applied while done is high (state DONE), which is safe
  // because the next acceptance happens only from IDLE.
  task automatic test_random_sweep(input int w, input int n);
    int          cyc;
    bit          ok;
    logic [63:0] ra, rb, exp;
    logic        rc;
    @(negedge clk);
    ra = {32'd0, $urandom};
    rb = {32'd0, $urandom};
    rc = 1'($urandom_range(0, 1));
    drive(w, 1'b1, ra, rb, rc);
    sb.push_back(model(w, ra, rb, rc));
    for (int i = 0; i < n; i++) begin
      wait_done(w, 2 * w + 10, cyc, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL sweep_w%0d_timeout[%0d]: got no done in %0d cycles, want one", w, i, cyc);
        set_start(w, 1'b0);
        sb.delete();
        return;
      end
      exp = sb.pop_front();
      if (get_res(w) !== exp) begin
        miscompares++;
        $display("[TB] FAIL sweep_w%0d[%0d]: got %h, want %h", w, i, get_res(w), exp);
      end
      vectors++;
      if (cyc != ((i == 0) ? w + 1 : w + 2) || get_busy(w) !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sweep_w%0d_spacing[%0d]: got %0d cycles busy=%b, want %0d busy=0",
                 w, i, cyc, get_busy(w), (i == 0) ? w + 1 : w + 2);
      end
      if (i < n - 1) begin
        ra = {32'd0, $urandom};
        rb = {32'd0, $urandom};
        rc = 1'($urandom_range(0, 1));
        drive(w, 1'b1, ra, rb, rc);
        sb.push_back(model(w, ra, rb, rc));
      end else begin
        set_start(w, 1'b0);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_mid_reset();
    test_random_sweep(8, 200);
    test_random_sweep(1, 50);
    test_random_sweep(32, 50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion by 2 ms, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
